// File: rtl/fc_weight_loader.sv
// rtl/fc_weight_loader.sv - streams weight/bias words into per-neuron RAMs and gates layer traffic until loaded
//
// Ports:
//   clk_i, reset_n_i           clock and synchronous active-low reset
//   start_i                    begin a load (honoured in idle and done only)
//   load_data_i/valid_i/ready_o incoming word stream, accepted on valid && ready
//   w_en_o, mem_addr_o, mem_data_o registered RAM write port, address {neuron, word}
//   busy_o, done_o             load in progress / all RAMs loaded
//   layer_valid_i/o, layer_yumi_i/o  inference handshake, passed through only when done
module fc_weight_loader #(
    parameter int WORD_SIZE             = 16,
    parameter int LAYER_HEIGHT          = 2,
    parameter int PREVIOUS_LAYER_HEIGHT = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    input  logic [WORD_SIZE-1:0]          load_data_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    output logic                          w_en_o,
    output logic [SEL_BITS+ADDR_BITS-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0]          mem_data_o,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          layer_valid_i,
    output logic                          layer_valid_o,
    input  logic                          layer_yumi_i,
    output logic                          layer_yumi_o
);

    localparam int SEL_BITS  = (LAYER_HEIGHT == 1) ? 1 : $clog2(LAYER_HEIGHT);
    localparam int ADDR_BITS = $clog2(PREVIOUS_LAYER_HEIGHT + 1);

    localparam logic [SEL_BITS-1:0]  LAST_NEURON = SEL_BITS'(LAYER_HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] LAST_WORD   = ADDR_BITS'(PREVIOUS_LAYER_HEIGHT);

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eLOAD  = 2'd1,
        eFLUSH = 2'd2,
        eDONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SEL_BITS-1:0]   neuron_q;
    logic [ADDR_BITS-1:0]  word_q;
    logic                  accept;
    logic                  final_word;
    logic                  restart;

    assign accept     = load_valid_i && load_ready_o;
    assign final_word = (neuron_q == LAST_NEURON) && (word_q == LAST_WORD);
    assign restart    = start_i && ((state_q == eIDLE) || (state_q == eDONE));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            eIDLE: begin
                if (start_i) state_d = eLOAD;
            end
            eLOAD: begin
                load_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept && final_word) state_d = eFLUSH;
            end
            // One cycle for the registered final write to land before done rises.
            eFLUSH: begin
                busy_o  = 1'b1;
                state_d = eDONE;
            end
            eDONE: begin
                done_o = 1'b1;
                if (start_i) state_d = eLOAD;
            end
            default: state_d = eIDLE;
        endcase
    end

    // Neuron-major counters; they move only on an accepted word so bubbles
    // neither skip nor repeat addresses.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            neuron_q <= '0;
            word_q   <= '0;
        end else if (restart) begin
            neuron_q <= '0;
            word_q   <= '0;
        end else if (accept) begin
            if (word_q == LAST_WORD) begin
                word_q   <= '0;
                neuron_q <= neuron_q + 1'b1;
            end else begin
                word_q <= word_q + 1'b1;
            end
        end
    end

    // Write port lags the accept by one cycle; address/data hold between writes.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_en_o     <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            w_en_o <= accept;
            if (accept) begin
                mem_addr_o <= {neuron_q, word_q};
                mem_data_o <= load_data_i;
            end
        end
    end

    assign layer_valid_o = layer_valid_i && done_o;
    assign layer_yumi_o  = layer_yumi_i && done_o;

endmodule

// File: tb/tb_fc_weight_loader.sv
// tb/tb_fc_weight_loader.sv - self-checking bench for fc_weight_loader
module tb_fc_weight_loader;

    localparam int W     = 16;
    localparam int LH    = 2;
    localparam int PLH   = 4;
    localparam int AB    = 3;
    localparam int TOTAL = LH * (PLH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          w_en;
    logic [3:0]    mem_addr;
    logic [W-1:0]  mem_data;
    logic          busy;
    logic          done;
    logic          lv_in = 1'b0;
    logic          lv_out;
    logic          ly_in = 1'b0;
    logic          ly_out;

    int total = 0;
    int bad   = 0;

    // Reference model: an active load accepts words, numbered by count; the
    // address is derived arithmetically from that count.
    bit          m_active;
    bit          m_flush;
    bit          m_done;
    int          m_cnt;
    bit          m_wen;
    int          m_addr;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    fc_weight_loader #(
        .WORD_SIZE(W), .LAYER_HEIGHT(LH), .PREVIOUS_LAYER_HEIGHT(PLH)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .load_data_i(load_data), .load_valid_i(load_valid), .load_ready_o(load_ready),
        .w_en_o(w_en), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .busy_o(busy), .done_o(done),
        .layer_valid_i(lv_in), .layer_valid_o(lv_out),
        .layer_yumi_i(ly_in), .layer_yumi_o(ly_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rn, input bit st, input bit v, input logic [W-1:0] d);
        bit pa;
        bit pf;
        pa = m_active;
        pf = m_flush;
        if (!rn) begin
            m_active = 0; m_flush = 0; m_done = 0; m_cnt = 0;
            m_wen = 0; m_addr = 0; m_data = '0;
            return;
        end
        m_wen = 0;
        if (pf) begin
            m_flush = 0;
            m_done  = 1;
        end
        if (pa) begin
            if (v) begin
                m_wen  = 1;
                m_addr = ((m_cnt / (PLH + 1)) << AB) + (m_cnt % (PLH + 1));
                m_data = d;
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_active = 0;
                    m_flush  = 1;
                end
            end
        end else if (!pf && st) begin
            m_active = 1;
            m_cnt    = 0;
            m_done   = 0;
        end
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs.
    task automatic cyc(input bit rn, input bit st, input bit v, input logic [W-1:0] d,
                       input bit lvi, input bit lyi);
        reset_n = rn; start = st; load_valid = v; load_data = d; lv_in = lvi; ly_in = lyi;
        #1;
        chk("load_ready", load_ready, m_active);
        chk("layer_valid_o", lv_out, lvi && m_done);
        chk("layer_yumi_o", ly_out, lyi && m_done);
        @(posedge clk);
        model_step(rn, st, v, d);
        #1;
        chk("w_en", w_en, m_wen);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        chk("busy", busy, m_active || m_flush);
        chk("done", done, m_done);
    endtask

    initial begin
        model_step(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;

        // Reset with every input high.
        cyc(0, 1, 1, 16'hFFFF, 1, 1);
        cyc(0, 1, 1, 16'hFFFF, 1, 1);
        chk("reset_ready", load_ready, 1'b0);

        // Streaming load 0x0100..0x0109 with layer inputs held high.
        cyc(1, 1, 0, '0, 1, 1);
        for (int i = 0; i < TOTAL; i++) cyc(1, 0, 1, 16'h0100 + 16'(i), 1, 1);
        cyc(1, 0, 0, '0, 1, 1);
        cyc(1, 0, 0, '0, 1, 1);
        chk("stream_done", done, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, 1'($urandom), 1'($urandom));

        // Restart from done, bubbles every other cycle, stray start mid-load.
        cyc(1, 1, 0, '0, 1, 1);
        chk("restart_done_drop", done, 1'b0);
        for (int i = 0; i < 2 * TOTAL; i++)
            cyc(1, (i == 5), (i % 2 == 0), 16'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, 1, 1);

        // Reset after 3 accepts, then a full reload.
        cyc(1, 1, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 16'h0100 + 16'(i), 1, 1);
        cyc(0, 1, 1, 16'hBEEF, 1, 1);
        cyc(1, 0, 1, 16'h1234, 1, 1);
        cyc(1, 1, 0, '0, 1, 1);
        for (int i = 0; i < TOTAL; i++) cyc(1, 0, 1, 16'h0100 + 16'(i), 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0), 1'($urandom),
                16'($urandom), 1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
